// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period
// rounding used by both the receive and the print/transmit paths.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // Clock cycles per UART bit, rounded to nearest.
    function automatic int unsigned bit_cyc(input int unsigned clk_freq,
                                            input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through FIFO for received bytes. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             push_ok
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wp_q, wp_d;
    logic [AW:0]      rp_q, rp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem_q[rp_q[AW-1:0]];

    // Next-state for storage and pointers.
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (push_ok) begin
            mem_d[wp_q[AW-1:0]] = din;
            wp_d = wp_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rp_d = rp_q + (AW+1)'(1);
        end
    end

    // Pointer and storage registers; storage needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Console UART receiver (8N1) feeding a byte FIFO with a valid/ready output.
// Define UART_PARITY_EN to receive 8 data bits + parity + stop instead.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned UART_FREQ  = 115200,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       usbclk,
    input  logic       usbrst,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned BIT_CYC = bit_cyc(CLK_FREQ, UART_FREQ);
    localparam int unsigned CW      = $clog2(BIT_CYC);
    // Counter restarts at each decision, so the start slot ends at its
    // centre+1 and every later slot ends a full bit period later.
    localparam logic [CW-1:0] START_END = CW'(BIT_CYC / 2);
    localparam logic [CW-1:0] SLOT_END  = CW'(BIT_CYC - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
    end

    logic          sync1_q, sync1_d;
    logic          rxs_q, rxs_d;
    logic          prev_q, prev_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    smp_q, smp_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
    logic          push, push_ok, full, empty;
    logic [CW-1:0] slot_end;
    logic          maj;
`ifdef UART_PARITY_EN
    logic          pe_q, pe_d;
    logic          pbad_q, pbad_d;
`endif

    assign slot_end = (state_q == ST_START) ? START_END : SLOT_END;
    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

    // Receiver FSM: edge detect, 3-sample majority per slot, frame checks.
    always_comb begin
        sync1_d = rxd;
        rxs_d   = sync1_q;
        prev_d  = rxs_q;
        state_d = state_q;
        cyc_d   = cyc_q;
        bitn_d  = bitn_q;
        shift_d = shift_q;
        smp_d   = smp_q;
        fe_d    = 1'b0;
        push    = 1'b0;
`ifdef UART_PARITY_EN
        pe_d    = 1'b0;
        pbad_d  = pbad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (prev_q && !rxs_q) begin
                    state_d = ST_START;
                    cyc_d   = '0;
                    bitn_d  = '0;
`ifdef UART_PARITY_EN
                    pbad_d  = 1'b0;
`endif
                end
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                cyc_d = cyc_q + CW'(1);
                if (cyc_q == slot_end - CW'(2)) smp_d[0] = rxs_q;
                if (cyc_q == slot_end - CW'(1)) smp_d[1] = rxs_q;
                if (cyc_q == slot_end) begin
                    cyc_d = '0;
                    case (state_q)
                        ST_START: state_d = maj ? ST_IDLE : ST_DATA;
                        ST_DATA: begin
                            shift_d = {maj, shift_q[7:1]};
                            bitn_d  = bitn_q + 3'd1;
                            if (bitn_q == 3'd7) begin
`ifdef UART_PARITY_EN
                                state_d = ST_PARITY;
`else
                                state_d = ST_STOP;
`endif
                            end
                        end
`ifdef UART_PARITY_EN
                        ST_PARITY: begin
                            if ((^shift_q ^ maj) != PARITY_ODD[0]) begin
                                pe_d   = 1'b1;
                                pbad_d = 1'b1;
                            end
                            state_d = ST_STOP;
                        end
`endif
                        default: begin
                            if (maj) begin
`ifdef UART_PARITY_EN
                                push = !pbad_q;
`else
                                push = 1'b1;
`endif
                                state_d = ST_IDLE;
                            end else begin
                                fe_d    = 1'b1;
                                state_d = ST_WAIT_HIGH;
                            end
                        end
                    endcase
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ov_d = push && !push_ok;
    end

    // Synchroniser, FSM and error-pulse registers.
    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
            smp_q   <= '0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_PARITY_EN
            pe_q    <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            rxs_q   <= rxs_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_PARITY_EN
            pe_q    <= pe_d;
            pbad_q  <= pbad_d;
`endif
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (usbclk),
        .rst     (usbrst),
        .push    (push),
        .pop     (ready),
        .din     (shift_q),
        .head    (dout),
        .full    (full),
        .empty   (empty),
        .push_ok (push_ok)
    );

    assign valid     = !empty;
    assign busy      = (state_q != ST_IDLE);
    assign frame_err = fe_q;
    assign overrun   = ov_q;
`ifdef UART_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (104 cycles/bit).
// Parity cases are exercised when UART_PARITY_EN is defined.
module tb_uart_rx_fifo;

    logic       usbclk = 1'b0;
    logic       usbrst, rxd, ready;
    logic [7:0] dout;
    logic       valid, frame_err, parity_err, overrun, busy;

    uart_rx_fifo #(
        .CLK_FREQ   (12000000),
        .UART_FREQ  (115200),
        .FIFO_DEPTH (4),
        .PARITY_ODD (0)
    ) dut (
        .usbclk     (usbclk),
        .usbrst     (usbrst),
        .rxd        (rxd),
        .dout       (dout),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 usbclk = ~usbclk;

`ifdef UART_PARITY_EN
    localparam int NSLOT = 11;
    localparam int RISE  = 1096;
`else
    localparam int NSLOT = 10;
    localparam int RISE  = 992;
`endif

    int unsigned cyc = 0;
    always @(posedge usbclk) cyc <= cyc + 1;

    int         passed = 0, failed = 0, total = 0;
    int         fe_cnt, pe_cnt, ov_cnt, vhi_cnt;
    int unsigned rise_cyc, start_cyc;
    logic       valid_d = 1'b0;
    logic [7:0] popped [$];

    // Observe outputs mid-cycle: pulses, pops and the valid rising edge.
    always @(negedge usbclk) begin
        if (valid && !valid_d) rise_cyc = cyc;
        if (valid) vhi_cnt++;
        if (valid && ready) popped.push_back(dout);
        if (frame_err) fe_cnt++;
        if (parity_err) pe_cnt++;
        if (overrun) ov_cnt++;
        valid_d = valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge usbclk);
            #1;
        end
    endtask

    task automatic clear_mon();
        fe_cnt = 0; pe_cnt = 0; ov_cnt = 0; vhi_cnt = 0;
        rise_cyc = 0;
        popped.delete();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        if (i < popped.size()) return {24'h0, popped[i]};
        return 32'hDEAD;
    endfunction

    // mode 0: whole slot; 1: data value only at c-1..c+1; 2: only c-1,c; 3: only c,c+1
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic par_v, input int mode);
        logic v;
        logic keep;
        start_cyc = cyc;
        for (int s = 0; s < NSLOT; s++) begin
            for (int c = 0; c < 104; c++) begin
                if (s == 0) v = 1'b0;
                else if (s <= 8) v = b[s-1];
                else if (s == NSLOT - 1) v = stop_v;
                else v = par_v;
                keep = 1'b1;
                if (s >= 1 && s <= 8) begin
                    case (mode)
                        1: keep = (c >= 51 && c <= 53);
                        2: keep = (c >= 51 && c <= 52);
                        3: keep = (c >= 52 && c <= 53);
                        default: keep = 1'b1;
                    endcase
                end
                rxd = keep ? v : ~v;
                @(posedge usbclk);
                #1;
            end
        end
    endtask

    initial begin
        rxd = 1'b1; ready = 1'b1; usbrst = 1'b1;
        clear_mon();
        tick(3);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_parity_err", {31'h0, parity_err}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        usbrst = 1'b0;
        tick(5);

        // Single byte, exact latency from first low drive to valid
        clear_mon();
        send_frame(8'h55, 1'b1, ^8'h55, 0);
        tick(10);
        check("b55_count", popped.size(), 1);
        check("b55_data", pop_at(0), 32'h55);
        check("b55_rise", rise_cyc - start_cyc, RISE);
        check("b55_vhi", vhi_cnt, 1);
        check("b55_errs", fe_cnt + pe_cnt + ov_cnt, 0);

        // Glitch shorter than half a bit is a false start
        clear_mon();
        rxd = 1'b0;
        tick(10);
        check("glitch_busy", {31'h0, busy}, 32'h1);
        tick(10);
        rxd = 1'b1;
        tick(200);
        check("glitch_idle", {31'h0, busy}, 32'h0);
        check("glitch_nopush", popped.size(), 0);
        check("glitch_errs", fe_cnt + pe_cnt + ov_cnt, 0);
        send_frame(8'hA3, 1'b1, ^8'hA3, 0);
        tick(10);
        check("bA3_count", popped.size(), 1);
        check("bA3_data", pop_at(0), 32'hA3);

        // Low stop bit, then held break
        clear_mon();
        send_frame(8'h12, 1'b0, ^8'h12, 0);
        tick(2000);
        check("brk_fe", fe_cnt, 1);
        check("brk_busy", {31'h0, busy}, 32'h1);
        check("brk_nopush", popped.size(), 0);
        rxd = 1'b1;
        tick(5);
        check("brk_release", {31'h0, busy}, 32'h0);
        send_frame(8'h34, 1'b1, ^8'h34, 0);
        tick(10);
        check("b34_data", pop_at(0), 32'h34);
        check("b34_count", popped.size(), 1);
        check("b34_fe", fe_cnt, 1);

        // Overrun on the fifth byte with consumer stalled
        clear_mon();
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, ^8'(i), 0);
        tick(10);
        check("ovr_cnt", ov_cnt, 1);
        check("ovr_valid", {31'h0, valid}, 32'h1);
        check("ovr_head", {24'h0, dout}, 32'h01);
        check("ovr_fe", fe_cnt, 0);
        ready = 1'b1;
        tick(10);
        check("ovr_npop", popped.size(), 4);
        for (int i = 0; i < 4; i++) check("ovr_order", pop_at(i), 32'(i + 1));
        check("ovr_empty", {31'h0, valid}, 32'h0);

        // Back-to-back frames with narrow data pulses around each centre
        clear_mon();
        send_frame(8'hC6, 1'b1, ^8'hC6, 1);
        tick(52);
        send_frame(8'h39, 1'b1, ^8'h39, 2);
        tick(52);
        send_frame(8'h5A, 1'b1, ^8'h5A, 3);
        tick(52);
        send_frame(8'h81, 1'b1, ^8'h81, 1);
        tick(10);
        check("maj_count", popped.size(), 4);
        check("maj_C6", pop_at(0), 32'hC6);
        check("maj_39", pop_at(1), 32'h39);
        check("maj_5A", pop_at(2), 32'h5A);
        check("maj_81", pop_at(3), 32'h81);
        check("maj_errs", fe_cnt + pe_cnt + ov_cnt, 0);

`ifdef UART_PARITY_EN
        // Even parity: 0x07 has three ones
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1, 0);
        tick(10);
        check("par_ok_data", pop_at(0), 32'h07);
        check("par_ok_pe", pe_cnt, 0);
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0, 0);
        tick(10);
        check("par_bad_pe", pe_cnt, 1);
        check("par_bad_nopush", popped.size(), 0);
        check("par_bad_fe", fe_cnt, 0);
        clear_mon();
        send_frame(8'h07, 1'b0, 1'b0, 0);
        rxd = 1'b1;
        tick(10);
        check("par_both_pe", pe_cnt, 1);
        check("par_both_fe", fe_cnt, 1);
`endif

        // Reset in the middle of a frame with a byte already queued
        clear_mon();
        ready = 1'b0;
        send_frame(8'h9E, 1'b1, ^8'h9E, 0);
        tick(5);
        check("mid_valid_pre", {31'h0, valid}, 32'h1);
        rxd = 1'b0;
        tick(104);
        rxd = 1'b1;
        tick(208);
        check("mid_busy_pre", {31'h0, busy}, 32'h1);
        usbrst = 1'b1;
        tick(1);
        check("mid_valid", {31'h0, valid}, 32'h0);
        check("mid_busy", {31'h0, busy}, 32'h0);
        usbrst = 1'b0;
        clear_mon();
        tick(1200);
        check("mid_nopush", vhi_cnt, 0);
        check("mid_errs", fe_cnt + pe_cnt + ov_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the board console; the inbound counterpart of the existing UART print/transmit path.
- Runs on the 12 MHz USB clock domain.
- Deserialises 8N1 frames from UART_RXD and buffers completed bytes in a small FIFO.
- Bytes leave through a valid/ready stream so demo logic can accept console commands, e.g. pause printing or select a report view.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz.
- UART_FREQ, 115200, baud rate. Bit period BIT_CYC = round(CLK_FREQ/UART_FREQ) = 104 at the defaults.
- FIFO_DEPTH, 4, byte FIFO depth; must be a power of two and at least 2.
- PARITY_ODD, 0, parity sense, used only when UART_PARITY_EN is defined. 0 = even, 1 = odd.

Ports:
- usbclk  in  1  sole clock; all logic is on its rising edge.
- usbrst  in  1  reset, synchronous, active-high.
- rxd  in  1  asynchronous serial input; line idles high.
- dout  out  8  FIFO head byte; valid only while `valid` is high.
- valid  out  1  FIFO not empty.
- ready  in  1  consumer accept; a pop occurs when valid && ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 without UART_PARITY_EN.
- overrun  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- busy  out  1  receiver state is not IDLE.

Behaviour:
- Reset (usbrst=1 on an edge):
  - both synchroniser flops set to 1.
  - state = IDLE; counters cleared.
  - FIFO emptied.
  - valid=0, dout=0, all error pulses 0, busy=0.
  - Reset mid-frame abandons the frame; the partial byte is never pushed.
- Synchroniser: rxd passes through 2 flops to give rxs. All timing below is relative to rxs.
- State IDLE:
  - on rxs 1→0 (prev=1, cur=0) at cycle T0, go to START; bit counter cleared, cycle counter=0.
- Sampling:
  - each bit slot is sampled at offsets c-1, c, c+1 around its centre c; the slot value is the 2-of-3 majority.
  - the decision is made at c+1.
  - start-bit centre = T0+BIT_CYC/2 (52).
  - data bit i (0..7, LSB first) centre = T0+52+104*(i+1).
- State START: majority=1 → false start; return to IDLE, no error. Majority=0 → DATA.
- State DATA: shift in 8 bits. Then go to PARITY (macro defined) or STOP.
- State STOP: stop-bit centre = T0+988, or T0+1092 with parity.
  - majority=1 → push byte at decision cycle T0+989; valid rises at T0+990 if the FIFO was empty; return to IDLE. A new start edge is accepted from the next cycle.
  - majority=0 → frame_err pulse, byte discarded, go to WAIT_HIGH.
- State WAIT_HIGH: stay until rxs=1 (covers line break), then IDLE. No further errors while waiting.
- FIFO:
  - first-word-fall-through: dout = head.
  - read/write pointers are log2(FIFO_DEPTH)+1 bits wide, wrapping naturally.
  - push when full → byte dropped, overrun pulse, contents unchanged.
  - simultaneous push and pop when full → pop first, push accepted, no overrun.
  - simultaneous push and pop when empty → push only; valid rises next cycle.
  - ready while valid=0 is ignored.
- Error pulses never coincide with a push in the same cycle.

Optional Feature:
- UART_PARITY_EN:
  - defined: frame is 8 data bits + 1 parity bit + stop. Parity slot centre = T0+52+936.
  - parity mismatch → parity_err pulse; byte dropped; the receiver still checks the stop bit. A low stop bit additionally gives frame_err and goes to WAIT_HIGH.
  - undefined: 8N1 only; parity_err constant 0; no parity state or logic present.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding IDLE/START/DATA/PARITY/STOP/WAIT_HIGH.
  - the BIT_CYC computation function, shared with the transmit print path so both ends agree on the rounding.
- One sub-module: uart_byte_fifo, a parameterised FWFT FIFO (push, pop, full, empty, head). The receiver FSM stays in uart_rx_fifo.

Test Plan:
- Send 0x55 at 104 cycles/bit, ready=1 → dout=0x55 with valid high exactly at T0+990 for one cycle; no error pulses.
- Glitch: rxd low for 20 cycles, then high → return to IDLE with no push and no error pulse; a following 0xA3 frame is received correctly.
- Stop bit forced low on byte 0x12 → single frame_err pulse; nothing pushed. rxd then held low for 2000 cycles → busy held, no further errors. rxd released, then 0x34 sent → 0x34 received.
- ready=0, send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 → overrun pulse on the 5th. Raise ready → pops 0x01,0x02,0x03,0x04 in order, then valid=0.
- Back-to-back frames (next start edge one bit-period after the previous stop centre), each bit slot with the bit value held for only cycles c-1..c+1 and the opposite value elsewhere in the slot → all bytes recovered from the majority sample.
- With UART_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 → accepted. Same byte with parity bit 0 → parity_err pulse, no push. Assert usbrst mid-frame → valid=0 and busy=0 on the next cycle.
